// File: rtl/pixel_stream_writer.sv
// RGB888 pixel stream to RGB565 video memory writer for the LED panel.
// Brightness scale, round, and a row-major write per pixel at fixed latency.
module pixel_stream_writer #(
    parameter int WIDTH  = 64,
    parameter int HEIGHT = 32
) (
    input  logic        ctrl_clk,
    input  logic        ctrl_resetn,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic        s_sof,
    input  logic [23:0] s_data,
    input  logic [7:0]  brightness,
    output logic        ctrl_en,
    output logic [15:0] ctrl_addr,
    output logic [16:0] ctrl_wdat,
    output logic        frame_done,
    output logic        short_frame,
    output logic [15:0] drop_count
);

    localparam int XW = $clog2(WIDTH);
    localparam int YW = $clog2(HEIGHT);
    localparam int IW = XW + YW;
    localparam logic [IW-1:0] LAST = IW'(WIDTH * HEIGHT - 1);

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_t;

    state_t        r_state;
    state_t        w_state_nx;
    logic [IW-1:0] r_idx;
    logic [IW-1:0] w_idx_nx;
    logic          w_acc;
    logic          w_load;
    logic [IW-1:0] w_load_idx;
    logic          w_last;
    logic          w_short;
    logic          w_drop;

    logic          r_s1_vld;
    logic [23:0]   r_s1_dat;
    logic [7:0]    r_s1_bri;
    logic [IW-1:0] r_s1_idx;
    logic          r_s1_last;

    logic          r_s2_vld;
    logic [7:0]    r_s2_r;
    logic [7:0]    r_s2_g;
    logic [7:0]    r_s2_b;
    logic [IW-1:0] r_s2_idx;
    logic          r_s2_last;

    logic          r_en;
    logic [15:0]   r_addr;
    logic [16:0]   r_wdat;
    logic          r_done;
    logic          r_short;
    logic [15:0]   r_drop;

    // c * (b + 1) never exceeds 16 bits, so the top byte is the scaled value
    function automatic logic [7:0] scale(input logic [7:0] c, input logic [7:0] b);
        logic [15:0] m;
        m = 16'(b) + 16'd1;
        return 8'((16'(c) * m) >> 8);
    endfunction

    function automatic logic [4:0] rnd5(input logic [7:0] c);
        logic [8:0] s;
        s = ({1'b0, c} + 9'd4) >> 3;
        return (s > 9'd31) ? 5'd31 : s[4:0];
    endfunction

    function automatic logic [5:0] rnd6(input logic [7:0] c);
        logic [8:0] s;
        s = ({1'b0, c} + 9'd2) >> 2;
        return (s > 9'd63) ? 6'd63 : s[5:0];
    endfunction

    assign s_ready = ctrl_resetn;
    assign w_acc   = s_valid && s_ready;

    always_ff @(posedge ctrl_clk) begin
        if (!ctrl_resetn) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_idx   <= w_idx_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_idx_nx   = r_idx;
        w_load     = 1'b0;
        w_load_idx = '0;
        w_last     = 1'b0;
        w_short    = 1'b0;
        w_drop     = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_acc) begin
                    if (s_sof) begin
                        w_load     = 1'b1;
                        w_idx_nx   = IW'(1);
                        w_state_nx = S_RUN;
                    end else begin
                        w_drop = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (w_acc) begin
                    w_load = 1'b1;
                    if (s_sof) begin
                        w_short  = 1'b1;
                        w_idx_nx = IW'(1);
                    end else begin
                        w_load_idx = r_idx;
                        w_idx_nx   = r_idx + IW'(1);
                        if (r_idx == LAST) begin
                            w_last     = 1'b1;
                            w_idx_nx   = '0;
                            w_state_nx = S_IDLE;
                        end
                    end
                end
            end
            default: begin
                w_state_nx = S_IDLE;
                w_idx_nx   = '0;
            end
        endcase
    end

    always_ff @(posedge ctrl_clk) begin
        if (!ctrl_resetn) begin
            r_short <= 1'b0;
            r_drop  <= '0;
        end else begin
            r_short <= w_short;
            if (w_drop && r_drop != 16'hFFFF) begin
                r_drop <= r_drop + 16'd1;
            end
        end
    end

    // Three register levels: capture, scale, round/pack
    always_ff @(posedge ctrl_clk) begin
        if (!ctrl_resetn) begin
            r_s1_vld  <= 1'b0;
            r_s1_dat  <= '0;
            r_s1_bri  <= '0;
            r_s1_idx  <= '0;
            r_s1_last <= 1'b0;
            r_s2_vld  <= 1'b0;
            r_s2_r    <= '0;
            r_s2_g    <= '0;
            r_s2_b    <= '0;
            r_s2_idx  <= '0;
            r_s2_last <= 1'b0;
            r_en      <= 1'b0;
            r_addr    <= '0;
            r_wdat    <= '0;
            r_done    <= 1'b0;
        end else begin
            r_s1_vld <= w_load;
            if (w_load) begin
                r_s1_dat  <= s_data;
                r_s1_bri  <= brightness;
                r_s1_idx  <= w_load_idx;
                r_s1_last <= w_last;
            end
            r_s2_vld <= r_s1_vld;
            if (r_s1_vld) begin
                r_s2_r    <= scale(r_s1_dat[23:16], r_s1_bri);
                r_s2_g    <= scale(r_s1_dat[15:8], r_s1_bri);
                r_s2_b    <= scale(r_s1_dat[7:0], r_s1_bri);
                r_s2_idx  <= r_s1_idx;
                r_s2_last <= r_s1_last;
            end
            r_en   <= r_s2_vld;
            r_done <= r_s2_vld && r_s2_last;
            if (r_s2_vld) begin
                r_addr <= {{(16 - IW){1'b0}}, r_s2_idx};
                r_wdat <= {1'b0, rnd5(r_s2_b), rnd6(r_s2_g), rnd5(r_s2_r)};
            end
        end
    end

    assign ctrl_en     = r_en;
    assign ctrl_addr   = r_addr;
    assign ctrl_wdat   = r_wdat;
    assign frame_done  = r_done;
    assign short_frame = r_short;
    assign drop_count  = r_drop;

endmodule

// File: tb/tb_pixel_stream_writer.sv
// Directed testbench for pixel_stream_writer.
// Each task drives one scenario and checks outputs inline.
module tb_pixel_stream_writer;

    logic        ctrl_clk;
    logic        ctrl_resetn;
    logic        s_valid;
    logic        s_ready;
    logic        s_sof;
    logic [23:0] s_data;
    logic [7:0]  brightness;
    logic        ctrl_en;
    logic [15:0] ctrl_addr;
    logic [16:0] ctrl_wdat;
    logic        frame_done;
    logic        short_frame;
    logic [15:0] drop_count;

    int total = 0;
    int bad   = 0;

    pixel_stream_writer dut (
        .ctrl_clk    (ctrl_clk),
        .ctrl_resetn (ctrl_resetn),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_sof       (s_sof),
        .s_data      (s_data),
        .brightness  (brightness),
        .ctrl_en     (ctrl_en),
        .ctrl_addr   (ctrl_addr),
        .ctrl_wdat   (ctrl_wdat),
        .frame_done  (frame_done),
        .short_frame (short_frame),
        .drop_count  (drop_count)
    );

    initial ctrl_clk = 1'b0;
    always #5 ctrl_clk = ~ctrl_clk;

    task automatic step();
        @(posedge ctrl_clk);
        #1;
    endtask

    function automatic logic [23:0] pat(input int i);
        return {8'(i), 8'(i * 3), 8'(i ^ 165)};
    endfunction

    function automatic logic [16:0] exp_wdat(input logic [23:0] d, input int bri);
        int r, g, b, r5, g6, b5;
        r  = (int'(d[23:16]) * (bri + 1)) / 256;
        g  = (int'(d[15:8]) * (bri + 1)) / 256;
        b  = (int'(d[7:0]) * (bri + 1)) / 256;
        r5 = (r + 4) / 8;
        g6 = (g + 2) / 4;
        b5 = (b + 4) / 8;
        if (r5 > 31) r5 = 31;
        if (g6 > 63) g6 = 63;
        if (b5 > 31) b5 = 31;
        return {1'b0, 5'(b5), 6'(g6), 5'(r5)};
    endfunction

    task automatic do_reset();
        ctrl_resetn = 1'b0;
        s_valid     = 1'b0;
        s_sof       = 1'b0;
        step();
        step();
        ctrl_resetn = 1'b1;
    endtask

    task automatic test_reset();
        ctrl_resetn = 1'b0;
        s_valid     = 1'b1;
        s_sof       = 1'b1;
        s_data      = 24'hFFFFFF;
        brightness  = 8'd255;
        step();
        step();
        total++;
        if (s_ready !== 1'b0) begin
            bad++;
            $display("FAIL rst_ready got %b want 0", s_ready);
        end
        total++;
        if ({ctrl_en, frame_done, short_frame} !== 3'b000) begin
            bad++;
            $display("FAIL rst_flags got %b want 000", {ctrl_en, frame_done, short_frame});
        end
        total++;
        if (ctrl_addr !== 16'h0 || ctrl_wdat !== 17'h0) begin
            bad++;
            $display("FAIL rst_bus got addr=%h wdat=%h want 0", ctrl_addr, ctrl_wdat);
        end
        total++;
        if (drop_count !== 16'h0) begin
            bad++;
            $display("FAIL rst_drop got %h want 0", drop_count);
        end
        ctrl_resetn = 1'b1;
        s_valid     = 1'b0;
        s_sof       = 1'b0;
        #1;
        total++;
        if (s_ready !== 1'b1) begin
            bad++;
            $display("FAIL run_ready got %b want 1", s_ready);
        end
    endtask

    task automatic test_full_frame();
        do_reset();
        brightness = 8'd255;
        for (int i = 0; i < 2050; i++) begin
            s_valid = (i < 2048);
            s_sof   = (i == 0);
            s_data  = pat(i);
            step();
            if (i >= 2) begin
                total++;
                if (ctrl_en !== 1'b1 || ctrl_addr !== 16'(i - 2)) begin
                    bad++;
                    $display("FAIL ff_write got en=%b addr=%h want en=1 addr=%h",
                             ctrl_en, ctrl_addr, 16'(i - 2));
                end
                total++;
                if (ctrl_wdat !== exp_wdat(pat(i - 2), 255)) begin
                    bad++;
                    $display("FAIL ff_wdat got %h want %h", ctrl_wdat, exp_wdat(pat(i - 2), 255));
                end
                total++;
                if (frame_done !== (i - 2 == 2047)) begin
                    bad++;
                    $display("FAIL ff_done got %b want %b at addr %h",
                             frame_done, (i - 2 == 2047), 16'(i - 2));
                end
            end else begin
                total++;
                if (ctrl_en !== 1'b0) begin
                    bad++;
                    $display("FAIL ff_lat got en=%b want 0 at cycle %0d", ctrl_en, i);
                end
            end
        end
        s_valid = 1'b1;
        s_sof   = 1'b0;
        step();
        s_valid = 1'b0;
        total++;
        if (drop_count !== 16'd1) begin
            bad++;
            $display("FAIL ff_idle got drop=%0d want 1", drop_count);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if (ctrl_en !== 1'b0 || frame_done !== 1'b0) begin
                bad++;
                $display("FAIL ff_after got en=%b done=%b want 0 0", ctrl_en, frame_done);
            end
        end
    endtask

    task automatic test_rounding();
        logic [23:0] din [3];
        logic [16:0] want [3];
        din[0]  = 24'hFFFFFF;
        din[1]  = 24'h040204;
        din[2]  = 24'h030103;
        want[0] = 17'h0FFFF;
        want[1] = 17'h00821;
        want[2] = 17'h00000;
        do_reset();
        brightness = 8'd255;
        for (int i = 0; i < 5; i++) begin
            s_valid = (i < 3);
            s_sof   = (i == 0);
            s_data  = (i < 3) ? din[i] : 24'h0;
            step();
            if (i >= 2) begin
                total++;
                if (ctrl_en !== 1'b1 || ctrl_addr !== 16'(i - 2) || ctrl_wdat !== want[i - 2]) begin
                    bad++;
                    $display("FAIL round got en=%b addr=%h wdat=%h want 1 %h %h",
                             ctrl_en, ctrl_addr, ctrl_wdat, 16'(i - 2), want[i - 2]);
                end
            end
        end
    endtask

    task automatic test_brightness();
        do_reset();
        s_data = 24'h808080;
        for (int i = 0; i < 4; i++) begin
            s_valid    = (i < 2);
            s_sof      = (i == 0);
            brightness = (i == 0) ? 8'd127 : 8'd0;
            step();
            if (i == 2) begin
                total++;
                if (ctrl_en !== 1'b1 || ctrl_wdat !== 17'h04208) begin
                    bad++;
                    $display("FAIL bright127 got en=%b wdat=%h want 1 04208", ctrl_en, ctrl_wdat);
                end
            end
            if (i == 3) begin
                total++;
                if (ctrl_en !== 1'b1 || ctrl_addr !== 16'h1 || ctrl_wdat !== 17'h0) begin
                    bad++;
                    $display("FAIL bright0 got en=%b addr=%h wdat=%h want 1 0001 00000",
                             ctrl_en, ctrl_addr, ctrl_wdat);
                end
            end
        end
    endtask

    task automatic test_early_sof();
        int j;
        do_reset();
        brightness = 8'd255;
        for (int i = 0; i < 106; i++) begin
            s_valid = (i < 104);
            s_sof   = (i == 0) || (i == 101);
            s_data  = pat(i);
            step();
            total++;
            if (short_frame !== (i == 101)) begin
                bad++;
                $display("FAIL short_pulse got %b want %b at cycle %0d", short_frame, (i == 101), i);
            end
            if (i >= 2) begin
                j = i - 2;
                total++;
                if (ctrl_en !== 1'b1 || ctrl_addr !== 16'((j <= 100) ? j : j - 101)) begin
                    bad++;
                    $display("FAIL short_addr got en=%b addr=%h want 1 %h",
                             ctrl_en, ctrl_addr, 16'((j <= 100) ? j : j - 101));
                end
                total++;
                if (frame_done !== 1'b0) begin
                    bad++;
                    $display("FAIL short_done got %b want 0", frame_done);
                end
            end
        end
    endtask

    task automatic test_idle_drops();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            s_valid = (i < 5);
            s_sof   = 1'b0;
            step();
            total++;
            if (ctrl_en !== 1'b0) begin
                bad++;
                $display("FAIL drop_en got %b want 0", ctrl_en);
            end
        end
        total++;
        if (drop_count !== 16'd5) begin
            bad++;
            $display("FAIL drop_cnt got %0d want 5", drop_count);
        end
    endtask

    task automatic test_drop_saturate();
        do_reset();
        s_valid = 1'b1;
        s_sof   = 1'b0;
        for (int i = 0; i < 70000; i++) begin
            step();
            if (i == 65533) begin
                total++;
                if (drop_count !== 16'hFFFE) begin
                    bad++;
                    $display("FAIL drop_near got %h want FFFE", drop_count);
                end
            end
        end
        s_valid = 1'b0;
        total++;
        if (drop_count !== 16'hFFFF) begin
            bad++;
            $display("FAIL drop_sat got %h want FFFF", drop_count);
        end
    endtask

    task automatic test_gapped_reset();
        logic [29:0] gap;
        logic        v;
        logic        vh [40];
        int          ah [40];
        int          cnt;
        gap = 30'b101100111010001101101110010111;
        cnt = 0;
        do_reset();
        brightness = 8'd255;
        for (int i = 0; i < 40; i++) begin
            v       = (i < 30) ? gap[i] : 1'b0;
            s_valid = v;
            s_sof   = !v || (cnt == 0);
            s_data  = pat(i);
            step();
            vh[i] = v;
            ah[i] = cnt;
            if (v) cnt++;
            total++;
            if (short_frame !== 1'b0) begin
                bad++;
                $display("FAIL gap_short got %b want 0 at cycle %0d", short_frame, i);
            end
            if (i >= 2) begin
                total++;
                if (ctrl_en !== vh[i - 2]) begin
                    bad++;
                    $display("FAIL gap_en got %b want %b at cycle %0d", ctrl_en, vh[i - 2], i);
                end
                if (vh[i - 2]) begin
                    total++;
                    if (ctrl_addr !== 16'(ah[i - 2])) begin
                        bad++;
                        $display("FAIL gap_addr got %h want %h", ctrl_addr, 16'(ah[i - 2]));
                    end
                end
            end
        end
        s_valid = 1'b1;
        s_sof   = 1'b0;
        step();
        step();
        s_valid     = 1'b0;
        ctrl_resetn = 1'b0;
        step();
        total++;
        if (ctrl_en !== 1'b0 || s_ready !== 1'b0) begin
            bad++;
            $display("FAIL mid_rst got en=%b ready=%b want 0 0", ctrl_en, s_ready);
        end
        step();
        ctrl_resetn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            total++;
            if (ctrl_en !== 1'b0 || frame_done !== 1'b0) begin
                bad++;
                $display("FAIL post_rst got en=%b done=%b want 0 0", ctrl_en, frame_done);
            end
        end
    endtask

    initial begin
        ctrl_resetn = 1'b0;
        s_valid     = 1'b0;
        s_sof       = 1'b0;
        s_data      = 24'h0;
        brightness  = 8'd255;
        test_reset();
        test_full_frame();
        test_rounding();
        test_brightness();
        test_early_sof();
        test_idle_drops();
        test_drop_saturate();
        test_gapped_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
